// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_pkg
// Description : Stereo-word defaults, packing helpers, handshake state type.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_pkg;

    localparam int c_dwidth  = 16;
    localparam int c_ddwidth = 2 * c_dwidth;

    // Per-direction handshake: idle, or acknowledge raised and awaiting req.
    typedef enum logic [0:0] {
        HS_IDLE = 1'b0,
        HS_ACK  = 1'b1
    } hs_state_t;

    // Channel 0 occupies the MSBs of a stereo word.
    function automatic logic [c_ddwidth-1:0] pack_stereo(
        input logic [c_dwidth-1:0] ch0,
        input logic [c_dwidth-1:0] ch1
    );
        return {ch0, ch1};
    endfunction

    function automatic logic [c_dwidth-1:0] stereo_ch0(input logic [c_ddwidth-1:0] word);
        return word[c_ddwidth-1:c_dwidth];
    endfunction

    function automatic logic [c_dwidth-1:0] stereo_ch1(input logic [c_ddwidth-1:0] word);
        return word[c_dwidth-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sample_fifo
// Description : Synchronous FIFO; storage cleared on reset so the head reads 0.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int                c_aw    = $clog2(DEPTH);
    localparam logic [c_aw:0]     c_depth = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty    = (r_count == '0);
    assign full     = (r_count == c_depth);
    assign count    = r_count;
    assign pop_data = r_mem[r_rd_ptr];

    // A concurrent pop frees the slot, so a push is legal even when full.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_responder.sv
`default_nettype none
// ============================================================================
// Module      : stream_responder
// Description : Host<->filter stereo bridge with TX/RX FIFOs and req/ack ports.
//               Define STREAM_RESPONDER_STATS_EN for tx_count/rx_count outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_responder
    import stream_pkg::*;
#(
    parameter int DWIDTH  = c_dwidth,
    parameter int DDWIDTH = 2 * DWIDTH,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               src_valid,
    input  logic [DDWIDTH-1:0] src_data,
    output logic               src_ready,
    input  logic               req_in,
    output logic               ack_in,
    output logic [DDWIDTH-1:0] data_in,
    input  logic               req_out,
    output logic               ack_out,
    input  logic [DDWIDTH-1:0] data_out,
    output logic               snk_valid,
    output logic [DDWIDTH-1:0] snk_data,
    input  logic               snk_ready
`ifdef STREAM_RESPONDER_STATS_EN
    ,
    output logic [31:0]        tx_count,
    output logic [31:0]        rx_count
`endif
);

    localparam int            c_aw    = $clog2(DEPTH);
    localparam logic [c_aw:0] c_depth = (c_aw + 1)'(DEPTH);

    hs_state_t     r_in_state;
    hs_state_t     r_out_state;
    logic          w_tx_full;
    logic          w_tx_empty;
    logic [c_aw:0] w_tx_count;
    logic          w_rx_full;
    logic          w_rx_empty;
    logic [c_aw:0] w_rx_count;
    logic          w_in_done;
    logic          w_out_done;
    logic          w_unused;

    assign ack_in     = (r_in_state  == HS_ACK);
    assign ack_out    = (r_out_state == HS_ACK);
    assign w_in_done  = req_in  && ack_in;
    assign w_out_done = req_out && ack_out;
    assign src_ready  = (w_tx_count < c_depth);
    assign snk_valid  = !w_rx_empty;
    assign w_unused   = &{1'b0, w_tx_full, w_rx_count};

    sample_fifo #(
        .WIDTH (DDWIDTH),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (src_valid && src_ready),
        .push_data (src_data),
        .pop       (w_in_done),
        .pop_data  (data_in),
        .full      (w_tx_full),
        .empty     (w_tx_empty),
        .count     (w_tx_count)
    );

    sample_fifo #(
        .WIDTH (DDWIDTH),
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_out_done),
        .push_data (data_out),
        .pop       (snk_ready),
        .pop_data  (snk_data),
        .full      (w_rx_full),
        .empty     (w_rx_empty),
        .count     (w_rx_count)
    );

    // Ack rises only on a sampled request with data available; it holds until
    // the request is seen alongside it, which completes the transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_state <= HS_IDLE;
        end else begin
            case (r_in_state)
                HS_IDLE: if (req_in && !w_tx_empty) r_in_state <= HS_ACK;
                HS_ACK:  if (req_in)                r_in_state <= HS_IDLE;
                default:                            r_in_state <= HS_IDLE;
            endcase
        end
    end

    // Output side withholds ack while the RX FIFO is full (backpressure).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_state <= HS_IDLE;
        end else begin
            case (r_out_state)
                HS_IDLE: if (req_out && !w_rx_full) r_out_state <= HS_ACK;
                HS_ACK:  if (req_out)               r_out_state <= HS_IDLE;
                default:                            r_out_state <= HS_IDLE;
            endcase
        end
    end

`ifdef STREAM_RESPONDER_STATS_EN
    logic [31:0] r_tx_count;
    logic [31:0] r_rx_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_count <= '0;
            r_rx_count <= '0;
        end else begin
            if (w_in_done)  r_tx_count <= r_tx_count + 32'd1;
            if (w_out_done) r_rx_count <= r_rx_count + 32'd1;
        end
    end

    assign tx_count = r_tx_count;
    assign rx_count = r_rx_count;
`endif

endmodule
`default_nettype wire

// File: doc/stream_responder.md
STREAM_RESPONDER -- requirements
Module: stream_responder

Interface
REQ-001 Parameter DWIDTH, default 16, width of one channel sample.
REQ-002 Parameter DDWIDTH, default 2*DWIDTH, width of one stereo word {ch0, ch1}, ch0 in MSBs.
REQ-003 Parameter DEPTH, default 4, power of two >= 2, entries per FIFO.
REQ-004 Ports SHALL be: clk  in  1  rising-edge clock; rst  in  1  reset, synchronous and active-high.
REQ-005 src_valid  in  1  host offers a stereo word; src_data  in  DDWIDTH  host word; src_ready  out  1  TX FIFO not full.
REQ-006 req_in  in  1  filter requests input; ack_in  out  1  data_in valid, transfer acknowledge; data_in  out  DDWIDTH  word to filter.
REQ-007 req_out  in  1  filter offers output; ack_out  out  1  output accepted; data_out  in  DDWIDTH  word from filter.
REQ-008 snk_valid  out  1  RX FIFO not empty; snk_data  out  DDWIDTH  RX FIFO head; snk_ready  in  1  host pops.

Function
REQ-009 TX path: host push when src_valid && src_ready; src_ready = TX count < DEPTH (combinational).
REQ-010 Input ack: ack_in registered; set to 1 at edge where req_in=1, ack_in=0, TX FIFO non-empty; data_in SHALL present TX head while ack_in=1.
REQ-011 Input transfer completes at edge where req_in && ack_in: TX pop, ack_in <= 0; ack_in SHALL be high exactly one cycle per transfer.
REQ-012 req_in with TX FIFO empty: ack_in stays 0 until a word is present; no underflow pop.
REQ-013 req_in dropped while ack_in=0: no action; ack_in never asserted without req_in high in the previous cycle.
REQ-014 Output ack: ack_out registered; set to 1 at edge where req_out=1, ack_out=0, RX count < DEPTH.
REQ-015 Output transfer completes at edge where req_out && ack_out: RX push of data_out, ack_out <= 0; one pulse, one push.
REQ-016 RX FIFO full with req_out high: ack_out held 0 (backpressure) until a host pop frees an entry.
REQ-017 Host pop when snk_valid && snk_ready; snk_data = RX head, valid same cycle as snk_valid.
REQ-018 Simultaneous push and pop on one FIFO in one cycle SHALL both occur, count unchanged, including at full (pop frees, push fills) and never at empty for pop.
REQ-019 FIFO pointers wrap modulo DEPTH; word order preserved end to end.
REQ-020 Minimum latency: req_in sampled -> ack_in high 1 cycle later; a word pushed by host is visible to filter the following cycle.

Reset
REQ-021 On rst at a rising edge: ack_in=0, ack_out=0, both FIFOs empty (src_ready=1, snk_valid=0), pointers 0, counters 0.
REQ-022 Reset mid-transfer discards in-flight words and pending acks; no push/pop occurs on the reset edge.
REQ-023 data_in and snk_data SHALL read 0 after reset until first push.

Configuration
REQ-024 Macro STREAM_RESPONDER_STATS_EN defined: outputs tx_count, rx_count (32 bits each) count completed filter-side input and output transfers, wrap at 2^32, cleared by rst.
REQ-025 Macro undefined: ports tx_count/rx_count absent, no counter logic; all other behaviour identical.

Structure
REQ-026 Shared package/header stream_pkg SHALL hold DWIDTH/DDWIDTH defaults and the stereo-word packing helpers shared with filter.
REQ-027 One sub-module sample_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count, synchronous active-high rst) instantiated twice, TX and RX.

Verification
REQ-028 Host pushes 0x0001_0002, filter raises req_in -> ack_in high one cycle later for exactly 1 cycle with data_in=0x00010002, FIFO empty after.
REQ-029 req_in high with TX empty for 10 cycles, then host push 0xAAAA_5555 -> ack_in stays 0 throughout, then pulses with 0xAAAA5555.
REQ-030 Filter offers 5 words 1..5 with DEPTH=4, snk_ready=0 -> 4 ack_out pulses, 5th req_out held unacked; one host pop -> 5th acked; host then reads 2,3,4,5.
REQ-031 Host pushes 8 words 0..7 through TX while filter consumes -> filter receives 0..7 in order across pointer wrap.
REQ-032 rst asserted the cycle ack_in is high -> ack_in=0, src_ready=1, snk_valid=0 next cycle; pending word not delivered.
REQ-033 With STREAM_RESPONDER_STATS_EN: 3 input and 2 output transfers -> tx_count=3, rx_count=2; after rst both 0.
